// File: rtl/ssd_scan_driver_if.sv
// Pin-side bundle of the multiplexed seven-segment driver: display inputs,
// message buffer write port, scroll handshake and the anode/segment outputs.
interface ssd_scan_driver_if #(
  parameter int NUM_DIGITS = 4,
  parameter int MSG_LEN    = 20
);
  localparam int EW = $clog2(NUM_DIGITS + 1);
  localparam int AW = $clog2(MSG_LEN);

  logic [1:0]              mode;
  logic [4*NUM_DIGITS-1:0] digits;
  logic [EW-1:0]           entry_idx;
  logic [7*NUM_DIGITS-1:0] pattern;
  logic                    msg_wr_en;
  logic [AW-1:0]           msg_wr_addr;
  logic [6:0]              msg_wr_data;
  logic                    scroll_start;
  logic                    scroll_busy;
  logic                    scroll_done;
  logic [NUM_DIGITS-1:0]   an;
  logic [6:0]              seg;
  logic [7*NUM_DIGITS-1:0] frame;

  modport master (
    output mode, digits, entry_idx, pattern,
    output msg_wr_en, msg_wr_addr, msg_wr_data, scroll_start,
    input  scroll_busy, scroll_done, an, seg, frame
  );

  modport slave (
    input  mode, digits, entry_idx, pattern,
    input  msg_wr_en, msg_wr_addr, msg_wr_data, scroll_start,
    output scroll_busy, scroll_done, an, seg, frame
  );
endinterface

// File: rtl/ssd_scan_driver.sv
// Multiplexed N-digit active-low seven-segment scanner with hex, masked entry,
// literal pattern and buffered message scroll modes.
module ssd_scan_driver #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 16,
  parameter int SCROLL_DIV  = 8,
  parameter int MSG_LEN     = 20
) (
  input  logic             clk,
  input  logic             rst,
  ssd_scan_driver_if.slave bus
);
  localparam int PW  = $clog2(REFRESH_DIV);
  localparam int DW  = $clog2(NUM_DIGITS);
  localparam int EW  = $clog2(NUM_DIGITS + 1);
  localparam int AW  = $clog2(MSG_LEN);
  localparam int AW1 = AW + 1;
  localparam int FW  = $clog2(SCROLL_DIV + 1);
  localparam int SW  = $clog2(MSG_LEN + NUM_DIGITS) + 1;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b1111110;

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_RUN = 1'b1} state_e;

  function automatic logic [6:0] hex_font(input logic [3:0] nib);
    case (nib)
      4'h0:    hex_font = 7'b0000001;
      4'h1:    hex_font = 7'b1001111;
      4'h2:    hex_font = 7'b0010010;
      4'h3:    hex_font = 7'b0000110;
      4'h4:    hex_font = 7'b1001100;
      4'h5:    hex_font = 7'b0100100;
      4'h6:    hex_font = 7'b0100000;
      4'h7:    hex_font = 7'b0001111;
      4'h8:    hex_font = 7'b0000000;
      4'h9:    hex_font = 7'b0000100;
      4'hA:    hex_font = 7'b0001000;
      4'hB:    hex_font = 7'b1100000;
      4'hC:    hex_font = 7'b0110001;
      4'hD:    hex_font = 7'b1000010;
      4'hE:    hex_font = 7'b0110000;
      4'hF:    hex_font = 7'b0111000;
      default: hex_font = SEG_BLANK;
    endcase
  endfunction

  logic [PW-1:0]           presc_q, presc_d;
  logic [DW-1:0]           p_q, p_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [6:0]              seg_q, seg_d;
  logic [7*NUM_DIGITS-1:0] frame_q, frame_d;
  logic [6:0]              buf_q [MSG_LEN];
  state_e                  state_q, state_d;
  logic [AW-1:0]           off_q, off_d;
  logic [FW-1:0]           fcnt_q, fcnt_d;
  logic                    done_q, done_d;

  logic          in_scroll_s, start_s, frame_end_s, step_s, last_step_s;
  logic [3:0]    nib_s;
  logic [SW-1:0] win_s;
  logic [6:0]    pick_s;

  always_comb begin
    in_scroll_s = (bus.mode == 2'd3);
    start_s     = bus.scroll_start && in_scroll_s && (state_q == S_IDLE);
    frame_end_s = (presc_q == PW'(REFRESH_DIV - 1)) && (p_q == DW'(NUM_DIGITS - 1));
    step_s      = frame_end_s && (fcnt_q == FW'(SCROLL_DIV - 1));
    last_step_s = step_s && (off_q == AW'(MSG_LEN - 1));
  end

  // Segment value for the digit currently addressed by the scan pointer
  always_comb begin
    nib_s  = bus.digits[4*(NUM_DIGITS-1-int'(p_q)) +: 4];
    win_s  = SW'(off_q) + SW'(p_q);
    pick_s = SEG_BLANK;
    case (bus.mode)
      2'd0: pick_s = hex_font(nib_s);
      2'd1: begin
        if (EW'(p_q) < bus.entry_idx) begin
          pick_s = SEG_DASH;
        end else if (EW'(p_q) == bus.entry_idx) begin
          pick_s = hex_font(nib_s);
        end else begin
          pick_s = SEG_BLANK;
        end
      end
      2'd2: pick_s = bus.pattern[7*(NUM_DIGITS-1-int'(p_q)) +: 7];
      2'd3: begin
        if (win_s < SW'(MSG_LEN)) begin
          pick_s = buf_q[win_s[AW-1:0]];
        end else begin
          pick_s = SEG_BLANK;
        end
      end
      default: pick_s = SEG_BLANK;
    endcase
  end

  // Digits are latched on the first cycle of their dwell (prescaler at zero)
  always_comb begin
    presc_d = presc_q;
    p_d     = p_q;
    an_d    = an_q;
    seg_d   = seg_q;
    frame_d = frame_q;
    if (presc_q == '0) begin
      an_d  = ~({{(NUM_DIGITS-1){1'b0}}, 1'b1} << (NUM_DIGITS - 1 - int'(p_q)));
      seg_d = pick_s;
      frame_d[7*(NUM_DIGITS-1-int'(p_q)) +: 7] = pick_s;
    end else begin
      an_d = an_q;
    end
    if (start_s) begin
      presc_d = '0;
      p_d     = '0;
    end else if (presc_q == PW'(REFRESH_DIV - 1)) begin
      presc_d = '0;
      if (p_q == DW'(NUM_DIGITS - 1)) begin
        p_d = '0;
      end else begin
        p_d = p_q + DW'(1);
      end
    end else begin
      presc_d = presc_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start_s) state_d = S_RUN;
        else         state_d = S_IDLE;
      end
      S_RUN: begin
        if (!in_scroll_s || last_step_s) state_d = S_IDLE;
        else                             state_d = S_RUN;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Leaving scroll mode is checked before the step so an abort never pulses done
  always_comb begin
    off_d  = off_q;
    fcnt_d = fcnt_q;
    done_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        off_d  = '0;
        fcnt_d = '0;
      end
      S_RUN: begin
        if (!in_scroll_s) begin
          off_d  = '0;
          fcnt_d = '0;
        end else if (step_s) begin
          fcnt_d = '0;
          if (last_step_s) begin
            off_d  = '0;
            done_d = 1'b1;
          end else begin
            off_d = off_q + AW'(1);
          end
        end else if (frame_end_s) begin
          fcnt_d = fcnt_q + FW'(1);
        end else begin
          fcnt_d = fcnt_q;
        end
      end
      default: begin
        off_d  = '0;
        fcnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      p_q     <= '0;
      an_q    <= '1;
      seg_q   <= SEG_BLANK;
      frame_q <= '1;
      off_q   <= '0;
      fcnt_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      p_q     <= p_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      frame_q <= frame_d;
      off_q   <= off_d;
      fcnt_q  <= fcnt_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MSG_LEN; i++) buf_q[i] <= SEG_BLANK;
    end else if (bus.msg_wr_en && ({1'b0, bus.msg_wr_addr} < AW1'(MSG_LEN))) begin
      buf_q[bus.msg_wr_addr] <= bus.msg_wr_data;
    end
  end

  assign bus.an          = an_q;
  assign bus.seg         = seg_q;
  assign bus.frame       = frame_q;
  assign bus.scroll_busy = (state_q == S_RUN);
  assign bus.scroll_done = done_q;
endmodule

// File: tb/tb_ssd_scan_driver.sv
// Self-checking bench for ssd_scan_driver: randomized display inputs checked
// against a behavioural model of the scan, modes and scroll timing.
module tb_ssd_scan_driver;
  localparam int ND = 4, RD = 4, SD = 2, ML = 8;
  localparam int FRAME = ND * RD;
  localparam int SCROLL_T = ML * SD * FRAME;
  localparam logic [6:0] BLANK = 7'b1111111;
  localparam logic [6:0] DASH  = 7'b1111110;
  localparam logic [6:0] FONT [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000, 7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  logic clk = 1'b0;
  logic rst;
  ssd_scan_driver_if #(.NUM_DIGITS(ND), .MSG_LEN(ML)) bus ();
  ssd_scan_driver #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .SCROLL_DIV(SD), .MSG_LEN(ML))
    dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int ph = 0;
  logic [6:0] mbuf [ML];
  logic [3:0] obs_an [FRAME];
  logic [6:0] obs_seg [FRAME];
  logic       obs_busy [FRAME];
  logic       obs_done [FRAME];
  logic [1:0] obs_mode [FRAME];

  task automatic tick();
    @(posedge clk);
    #1;
    ph = (ph + 1) % FRAME;
  endtask

  task automatic align();
    while (ph != 0) tick();
  endtask

  // One full scan frame; optional scroll_start pulse or switch to mode 0 at cycle k.
  task automatic run_frame(input int start_k, input int abort_k);
    for (int k = 0; k < FRAME; k++) begin
      if (k == start_k) bus.scroll_start = 1'b1;
      if (k == abort_k) bus.mode = 2'd0;
      obs_mode[k] = bus.mode;
      tick();
      bus.scroll_start = 1'b0;
      obs_an[k]   = bus.an;
      obs_seg[k]  = bus.seg;
      obs_busy[k] = bus.scroll_busy;
      obs_done[k] = bus.scroll_done;
    end
  endtask

  task automatic start_scroll();
    bus.mode = 2'd3;
    bus.scroll_start = 1'b1;
    tick();
    bus.scroll_start = 1'b0;
    ph = 0;
  endtask

  function automatic logic [3:0] exp_an(input int d);
    logic [3:0] a;
    a = 4'b1111;
    a[ND-1-d] = 1'b0;
    return a;
  endfunction

  function automatic logic [6:0] exp_seg(input logic [1:0] m, input int d, input int off);
    int nib;
    nib = int'((bus.digits >> (4 * (ND - 1 - d))) & 16'h000F);
    case (m)
      2'd0: return FONT[nib];
      2'd1: begin
        if (d < int'(bus.entry_idx)) return DASH;
        else if (d == int'(bus.entry_idx)) return FONT[nib];
        else return BLANK;
      end
      2'd2: return bus.pattern[7*(ND-1-d) +: 7];
      default: begin
        if (off + d < ML) return mbuf[off + d];
        else return BLANK;
      end
    endcase
  endfunction

  function automatic logic [7*ND-1:0] exp_frame(input int off);
    logic [7*ND-1:0] f;
    for (int d = 0; d < ND; d++) f[7*(ND-1-d) +: 7] = exp_seg(obs_mode[d*RD], d, off);
    return f;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    bus.mode = 2'd0; bus.digits = 16'h0000; bus.entry_idx = 3'd0;
    bus.pattern = {(7*ND){1'b1}}; bus.msg_wr_en = 1'b0; bus.msg_wr_addr = 3'd0;
    bus.msg_wr_data = 7'd0; bus.scroll_start = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    n_checks++; if (bus.an !== 4'b1111) begin n_fail++; $display("FAIL reset_an: got %b expected 1111", bus.an); end
    n_checks++; if (bus.seg !== BLANK) begin n_fail++; $display("FAIL reset_seg: got %b expected %b", bus.seg, BLANK); end
    n_checks++; if (bus.scroll_busy !== 1'b0 || bus.scroll_done !== 1'b0) begin
      n_fail++; $display("FAIL reset_busy_done: got %b%b expected 00", bus.scroll_busy, bus.scroll_done); end
    n_checks++; if (bus.frame !== {(7*ND){1'b1}}) begin n_fail++; $display("FAIL reset_frame: got %h expected all ones", bus.frame); end
    for (int i = 0; i < ML; i++) mbuf[i] = BLANK;
    rst = 1'b0;
    ph = 0;
    run_frame(-1, -1);
    for (int k = 0; k < FRAME; k++) begin
      n_checks++; if (obs_an[k] !== exp_an(k / RD)) begin
        n_fail++; $display("FAIL reset_scan_an cycle %0d: got %b expected %b", k, obs_an[k], exp_an(k / RD)); end
    end
  endtask

  task automatic test_hex();
    for (int r = 0; r < 4; r++) begin
      bus.mode = 2'd0;
      bus.digits = (r == 0) ? 16'h0A3F : 16'($urandom);
      run_frame(-1, -1);
      for (int k = 0; k < FRAME; k++) begin
        n_checks++; if (obs_an[k] !== exp_an(k / RD) || obs_seg[k] !== exp_seg(obs_mode[(k/RD)*RD], k / RD, 0)) begin
          n_fail++; $display("FAIL hex_scan cycle %0d: got an=%b seg=%b expected an=%b seg=%b", k, obs_an[k], obs_seg[k],
                             exp_an(k / RD), exp_seg(obs_mode[(k/RD)*RD], k / RD, 0)); end
      end
      n_checks++; if (bus.frame !== exp_frame(0)) begin
        n_fail++; $display("FAIL hex_frame: got %h expected %h", bus.frame, exp_frame(0)); end
      if (r == 0) begin
        n_checks++; if (bus.frame !== {7'b0000001, 7'b0001000, 7'b0000110, 7'b0111000}) begin
          n_fail++; $display("FAIL hex_0A3F_frame: got %h expected %h", bus.frame,
                             {7'b0000001, 7'b0001000, 7'b0000110, 7'b0111000}); end
      end
    end
  endtask

  task automatic test_masked();
    for (int r = 0; r < 5; r++) begin
      bus.mode = 2'd1;
      bus.digits = (r < 2) ? 16'h1234 : 16'($urandom);
      bus.entry_idx = (r == 0) ? 3'd2 : (r == 1) ? 3'd4 : 3'($urandom_range(0, ND));
      run_frame(-1, -1);
      for (int k = 0; k < FRAME; k++) begin
        n_checks++; if (obs_seg[k] !== exp_seg(obs_mode[(k/RD)*RD], k / RD, 0)) begin
          n_fail++; $display("FAIL masked_seg idx=%0d cycle %0d: got %b expected %b", bus.entry_idx, k, obs_seg[k],
                             exp_seg(obs_mode[(k/RD)*RD], k / RD, 0)); end
      end
      if (r == 0) begin
        n_checks++; if (bus.frame !== {DASH, DASH, 7'b0000110, BLANK}) begin
          n_fail++; $display("FAIL masked_idx2_frame: got %h expected %h", bus.frame, {DASH, DASH, 7'b0000110, BLANK}); end
      end else if (r == 1) begin
        n_checks++; if (bus.frame !== {DASH, DASH, DASH, DASH}) begin
          n_fail++; $display("FAIL masked_idx4_frame: got %h expected %h", bus.frame, {DASH, DASH, DASH, DASH}); end
      end
    end
  endtask

  task automatic test_pattern();
    for (int r = 0; r < 2; r++) begin
      bus.mode = 2'd2;
      bus.pattern = 28'($urandom);
      run_frame(-1, -1);
      for (int k = 0; k < FRAME; k++) begin
        n_checks++; if (obs_seg[k] !== exp_seg(2'd2, k / RD, 0)) begin
          n_fail++; $display("FAIL pattern_seg cycle %0d: got %b expected %b", k, obs_seg[k], exp_seg(2'd2, k / RD, 0)); end
      end
      n_checks++; if (bus.frame !== bus.pattern) begin
        n_fail++; $display("FAIL pattern_frame: got %h expected %h", bus.frame, bus.pattern); end
    end
  endtask

  task automatic test_scroll();
    int pulses, done_ts, ts;
    for (int i = 0; i < ML; i++) begin
      bus.msg_wr_en = 1'b1; bus.msg_wr_addr = 3'(i); bus.msg_wr_data = FONT[i];
      tick();
      mbuf[i] = FONT[i];
    end
    bus.msg_wr_en = 1'b0;
    bus.mode = 2'd3;
    align();
    run_frame(-1, -1);
    n_checks++; if (bus.frame !== exp_frame(0) || obs_busy[FRAME-1] !== 1'b0) begin
      n_fail++; $display("FAIL scroll_static_window: got %h busy=%b expected %h busy=0", bus.frame, obs_busy[FRAME-1], exp_frame(0)); end
    start_scroll();
    n_checks++; if (bus.scroll_busy !== 1'b1) begin n_fail++; $display("FAIL scroll_busy_rise: got %b expected 1", bus.scroll_busy); end
    pulses = 0; done_ts = -1;
    for (int f = 0; f < SCROLL_T / FRAME; f++) begin
      run_frame(-1, -1);
      for (int k = 0; k < FRAME; k++) begin
        ts = f * FRAME + k + 1;
        n_checks++; if (obs_an[k] !== exp_an(k / RD) || obs_seg[k] !== exp_seg(2'd3, k / RD, f / 2)) begin
          n_fail++; $display("FAIL scroll_window f=%0d cycle %0d: got an=%b seg=%b expected an=%b seg=%b", f, k,
                             obs_an[k], obs_seg[k], exp_an(k / RD), exp_seg(2'd3, k / RD, f / 2)); end
        n_checks++; if (obs_busy[k] !== (ts < SCROLL_T)) begin
          n_fail++; $display("FAIL scroll_busy ts=%0d: got %b expected %b", ts, obs_busy[k], ts < SCROLL_T); end
        if (obs_done[k] === 1'b1) begin pulses++; done_ts = ts; end
      end
      if (f == 14) begin
        n_checks++; if (bus.frame !== {FONT[7], BLANK, BLANK, BLANK}) begin
          n_fail++; $display("FAIL scroll_last_window: got %h expected %h", bus.frame, {FONT[7], BLANK, BLANK, BLANK}); end
      end
    end
    n_checks++; if (pulses != 1 || done_ts != SCROLL_T) begin
      n_fail++; $display("FAIL scroll_done_timing: got %0d pulses at %0d expected 1 at %0d", pulses, done_ts, SCROLL_T); end
    run_frame(-1, -1);
    n_checks++; if (bus.frame !== exp_frame(0) || obs_done[0] !== 1'b0 || obs_busy[0] !== 1'b0) begin
      n_fail++; $display("FAIL scroll_after_done: got %h busy=%b done=%b expected %h 0 0", bus.frame, obs_busy[0], obs_done[0], exp_frame(0)); end
  endtask

  task automatic test_abort();
    int pulses;
    for (int i = 0; i < ML; i++) begin
      bus.msg_wr_en = 1'b1; bus.msg_wr_addr = 3'(i); bus.msg_wr_data = 7'($urandom);
      mbuf[i] = bus.msg_wr_data;
      tick();
    end
    bus.msg_wr_en = 1'b0;
    pulses = 0;
    start_scroll();
    for (int f = 0; f < 7; f++) run_frame(-1, -1);
    n_checks++; if (bus.frame !== exp_frame(3)) begin
      n_fail++; $display("FAIL abort_window_off3: got %h expected %h", bus.frame, exp_frame(3)); end
    bus.mode = 2'd0;
    run_frame(-1, -1);
    n_checks++; if (obs_busy[0] !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b expected 0", obs_busy[0]); end
    for (int k = 0; k < FRAME; k++) if (obs_done[k] === 1'b1) pulses++;
    bus.mode = 2'd3;
    run_frame(-1, -1);
    n_checks++; if (bus.frame !== exp_frame(0) || obs_busy[FRAME-1] !== 1'b0) begin
      n_fail++; $display("FAIL abort_reenter_window: got %h busy=%b expected %h busy=0", bus.frame, obs_busy[FRAME-1], exp_frame(0)); end
    for (int k = 0; k < FRAME; k++) if (obs_done[k] === 1'b1) pulses++;
    start_scroll();
    for (int f = 0; f < SCROLL_T / FRAME - 1; f++) begin
      run_frame(-1, -1);
      for (int k = 0; k < FRAME; k++) if (obs_done[k] === 1'b1) pulses++;
    end
    run_frame(-1, FRAME - 1);
    n_checks++; if (obs_busy[FRAME-2] !== 1'b1 || obs_busy[FRAME-1] !== 1'b0) begin
      n_fail++; $display("FAIL abort_on_step_busy: got %b%b expected 10", obs_busy[FRAME-2], obs_busy[FRAME-1]); end
    for (int k = 0; k < FRAME; k++) if (obs_done[k] === 1'b1) pulses++;
    run_frame(-1, -1);
    for (int k = 0; k < FRAME; k++) if (obs_done[k] === 1'b1) pulses++;
    n_checks++; if (pulses != 0) begin n_fail++; $display("FAIL abort_no_done: got %0d pulses expected 0", pulses); end
  endtask

  task automatic test_back_to_back();
    int pulses, done_ts, ts;
    pulses = 0; done_ts = -1;
    start_scroll();
    for (int f = 0; f < SCROLL_T / FRAME; f++) begin
      run_frame((f == 4) ? 7 : -1, -1);
      for (int k = 0; k < FRAME; k++) begin
        ts = f * FRAME + k + 1;
        n_checks++; if (obs_seg[k] !== exp_seg(2'd3, k / RD, f / 2)) begin
          n_fail++; $display("FAIL restart_window f=%0d cycle %0d: got %b expected %b", f, k, obs_seg[k], exp_seg(2'd3, k / RD, f / 2)); end
        if (obs_done[k] === 1'b1) begin pulses++; done_ts = ts; end
      end
    end
    n_checks++; if (pulses != 1 || done_ts != SCROLL_T) begin
      n_fail++; $display("FAIL restart_done_timing: got %0d pulses at %0d expected 1 at %0d", pulses, done_ts, SCROLL_T); end
  endtask

  task automatic test_reset_mid_scroll();
    int pulses;
    pulses = 0;
    start_scroll();
    for (int f = 0; f < 3; f++) run_frame(-1, -1);
    rst = 1'b1;
    bus.scroll_start = 1'b1;
    tick();
    bus.scroll_start = 1'b0;
    tick();
    n_checks++; if (bus.scroll_busy !== 1'b0 || bus.scroll_done !== 1'b0 || bus.an !== 4'b1111 || bus.seg !== BLANK) begin
      n_fail++; $display("FAIL midreset_outputs: got busy=%b done=%b an=%b seg=%b expected 0 0 1111 %b",
                         bus.scroll_busy, bus.scroll_done, bus.an, bus.seg, BLANK); end
    n_checks++; if (bus.frame !== {(7*ND){1'b1}}) begin n_fail++; $display("FAIL midreset_frame: got %h expected all ones", bus.frame); end
    rst = 1'b0;
    ph = 0;
    for (int i = 0; i < ML; i++) mbuf[i] = BLANK;
    for (int f = 0; f < 14; f++) begin
      run_frame(-1, -1);
      for (int k = 0; k < FRAME; k++) begin
        n_checks++; if (obs_busy[k] !== 1'b0 || obs_seg[k] !== exp_seg(2'd3, k / RD, 0)) begin
          n_fail++; $display("FAIL midreset_blank f=%0d cycle %0d: got busy=%b seg=%b expected busy=0 seg=%b", f, k,
                             obs_busy[k], obs_seg[k], exp_seg(2'd3, k / RD, 0)); end
        if (obs_done[k] === 1'b1) pulses++;
      end
    end
    n_checks++; if (pulses != 0) begin n_fail++; $display("FAIL midreset_no_done: got %0d pulses expected 0", pulses); end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_hex();
    test_masked();
    test_pattern();
    test_scroll();
    test_abort();
    test_back_to_back();
    test_reset_mid_scroll();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
